// File: rtl/melody_sequencer_pkg.sv
// melody_sequencer_pkg
//   Shared definitions for the melody sequencer slice:
//   - Beeper tone codes (rest, L1..H7, end marker)
//   - ROM word layout {tone[4:0], dur[2:0]}
//   - sequencer FSM state encoding
//   - small helpers for decoding and building ROM words
package melody_sequencer_pkg;

  localparam int TONE_W   = 5;
  localparam int DUR_W    = 3;
  localparam int WORD_W   = TONE_W + DUR_W;
  localparam int TONE_MSB = 7;
  localparam int TONE_LSB = 3;
  localparam int DUR_MSB  = 2;
  localparam int DUR_LSB  = 0;

  localparam logic [TONE_W-1:0] TONE_REST = 5'd0;
  localparam logic [TONE_W-1:0] TONE_L1   = 5'd1;
  localparam logic [TONE_W-1:0] TONE_L2   = 5'd2;
  localparam logic [TONE_W-1:0] TONE_L3   = 5'd3;
  localparam logic [TONE_W-1:0] TONE_L4   = 5'd4;
  localparam logic [TONE_W-1:0] TONE_L5   = 5'd5;
  localparam logic [TONE_W-1:0] TONE_L6   = 5'd6;
  localparam logic [TONE_W-1:0] TONE_L7   = 5'd7;
  localparam logic [TONE_W-1:0] TONE_M1   = 5'd8;
  localparam logic [TONE_W-1:0] TONE_M2   = 5'd9;
  localparam logic [TONE_W-1:0] TONE_M3   = 5'd10;
  localparam logic [TONE_W-1:0] TONE_M4   = 5'd11;
  localparam logic [TONE_W-1:0] TONE_M5   = 5'd12;
  localparam logic [TONE_W-1:0] TONE_M6   = 5'd13;
  localparam logic [TONE_W-1:0] TONE_M7   = 5'd14;
  localparam logic [TONE_W-1:0] TONE_H1   = 5'd15;
  localparam logic [TONE_W-1:0] TONE_H2   = 5'd16;
  localparam logic [TONE_W-1:0] TONE_H3   = 5'd17;
  localparam logic [TONE_W-1:0] TONE_H4   = 5'd18;
  localparam logic [TONE_W-1:0] TONE_H5   = 5'd19;
  localparam logic [TONE_W-1:0] TONE_H6   = 5'd20;
  localparam logic [TONE_W-1:0] TONE_H7   = 5'd21;
  localparam logic [TONE_W-1:0] TONE_END  = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4,
    ST_END   = 3'd5
  } state_e;

  // Codes 22..30 are treated as rests, so only 1..21 actually sound.
  function automatic logic is_audible(input logic [TONE_W-1:0] t);
    return (t >= TONE_L1) && (t <= TONE_H7);
  endfunction

  function automatic logic [WORD_W-1:0] note(input logic [TONE_W-1:0] t,
                                             input logic [DUR_W-1:0]  d);
    return {t, d};
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if
//   Control/Beeper-side bundle of the melody sequencer.
//   master : control logic (drives play/stop, observes status)
//   slave  : melody_sequencer (drives Beeper tone and status)
//   Signals: play, stop (1-cycle pulses); tone_en, tone[4:0] (to Beeper);
//            busy, note_idx[ADDR_W-1:0], done (status).
interface melody_sequencer_if
  import melody_sequencer_pkg::*;
#(
  parameter int ADDR_W = 5
);
  logic              play;
  logic              stop;
  logic              tone_en;
  logic [TONE_W-1:0] tone;
  logic              busy;
  logic [ADDR_W-1:0] note_idx;
  logic              done;

  modport master (output play, stop,
                  input  tone_en, tone, busy, note_idx, done);
  modport slave  (input  play, stop,
                  output tone_en, tone, busy, note_idx, done);
endinterface

// File: rtl/melody_rom.sv
// melody_rom
//   Synchronous note ROM, 2**ADDR_W x 8, one cycle read latency.
//   Word layout {tone[4:0], dur[2:0]}; unlisted addresses hold the end marker.
//   ROM_SEL picks the table: 0 = production tune, 1 = short check pattern,
//   2 = empty melody (end marker at address 0).
//   Ports: clk_in, rst_n_in (async, active low), i_addr, o_data.
module melody_rom
  import melody_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int ROM_SEL = 0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [WORD_W-1:0] o_data
);

  logic [31:0]       w_idx;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] r_data;

  assign w_idx  = 32'(i_addr);
  assign o_data = r_data;

  always_comb begin
    w_word = note(TONE_END, 3'd0);
    case (ROM_SEL)
      1: begin
        case (w_idx)
          0:       w_word = note(TONE_M1,   3'd1);
          1:       w_word = note(TONE_REST, 3'd0);
          2:       w_word = note(TONE_H1,   3'd0);
          default: ;
        endcase
      end
      2: ;
      default: begin
        // Twinkle twinkle: 1 1 5 5 6 6 5- 4 4 3 3 2 2 1-
        case (w_idx)
          0:       w_word = note(TONE_M1, 3'd1);
          1:       w_word = note(TONE_M1, 3'd1);
          2:       w_word = note(TONE_M5, 3'd1);
          3:       w_word = note(TONE_M5, 3'd1);
          4:       w_word = note(TONE_M6, 3'd1);
          5:       w_word = note(TONE_M6, 3'd1);
          6:       w_word = note(TONE_M5, 3'd3);
          7:       w_word = note(TONE_M4, 3'd1);
          8:       w_word = note(TONE_M4, 3'd1);
          9:       w_word = note(TONE_M3, 3'd1);
          10:      w_word = note(TONE_M3, 3'd1);
          11:      w_word = note(TONE_M2, 3'd1);
          12:      w_word = note(TONE_M2, 3'd1);
          13:      w_word = note(TONE_M1, 3'd3);
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_data <= '0;
    else           r_data <= w_word;
  end

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer
//   Walks the note ROM and drives the Beeper's tone_en/tone inputs. Each note
//   sounds for (dur+1) tempo ticks, followed by a silent gap of GAP_CYC cycles
//   so repeated notes stay distinct. A tone code of 31 ends the melody.
//   Ports: clk_in, rst_n_in (async, active low), bus (melody_sequencer_if.slave:
//          play/stop in; tone_en, tone, busy, note_idx, done out).
//   Build option: define MELODY_LOOP_EN to repeat the melody until stop; an end
//   marker at address 0 still returns to IDLE.
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int CLK_HZ   = 12000000,
  parameter int TICK_DIV = 1499999,
  parameter int GAP_CYC  = 120000,
  parameter int ADDR_W   = 5,
  parameter int ROM_SEL  = 0
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  melody_sequencer_if.slave  bus
);

  localparam int DIV_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  // The gap must exist and a tick may not exceed one second.
  if ((GAP_CYC < 1) || (TICK_DIV >= CLK_HZ)) begin : g_param_check
    $error("melody_sequencer: GAP_CYC must be >= 1 and TICK_DIV < CLK_HZ");
  end

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [TONE_W-1:0]  r_tone;
  logic [DUR_W-1:0]   r_dur;
  logic [DIV_W-1:0]   r_div;
  logic [DUR_W-1:0]   r_tick;
  logic [GAP_W-1:0]   r_gap;
  logic [WORD_W-1:0]  w_rom_word;
  logic [TONE_W-1:0]  w_rom_tone;
  logic [DUR_W-1:0]   w_rom_dur;
  logic               w_note_done;
  logic               w_gap_done;

  melody_rom #(
    .ADDR_W  (ADDR_W),
    .ROM_SEL (ROM_SEL)
  ) u_rom (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_addr   (r_addr),
    .o_data   (w_rom_word)
  );

  assign w_rom_tone  = w_rom_word[TONE_MSB:TONE_LSB];
  assign w_rom_dur   = w_rom_word[DUR_MSB:DUR_LSB];
  assign w_note_done = (r_div == DIV_LAST) && (r_tick == r_dur);
  assign w_gap_done  = (r_gap == GAP_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    bus.tone_en  = 1'b0;
    bus.tone     = TONE_REST;
    bus.busy     = (r_state != ST_IDLE);
    bus.done     = 1'b0;
    bus.note_idx = r_addr;

    case (r_state)
      ST_IDLE:  if (bus.play && !bus.stop) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = (w_rom_tone == TONE_END) ? ST_END : ST_PLAY;
      ST_PLAY: begin
        bus.tone_en = is_audible(r_tone);
        bus.tone    = r_tone;
        if (w_note_done) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (w_gap_done) w_state_nxt = (r_addr == ADDR_LAST) ? ST_END : ST_FETCH;
      end
      ST_END: begin
        bus.done = 1'b1;
`ifdef MELODY_LOOP_EN
        // END is only reached at addr 0 via an end marker there: don't spin.
        w_state_nxt = (r_addr != '0) ? ST_FETCH : ST_IDLE;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default:  w_state_nxt = ST_IDLE;
    endcase

    if (bus.stop && (r_state != ST_IDLE)) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_tone  <= TONE_REST;
      r_dur   <= '0;
      r_div   <= '0;
      r_tick  <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;

      // note_idx reads 0 whenever the block is idle; a loop restarts at 0.
      if (w_state_nxt == ST_IDLE)
        r_addr <= '0;
      else if ((r_state == ST_GAP) && (w_state_nxt == ST_FETCH))
        r_addr <= r_addr + 1'b1;
      else if ((r_state == ST_END) && (w_state_nxt == ST_FETCH))
        r_addr <= '0;

      // Counters restart on PLAY entry so the first tick is full length.
      if ((r_state == ST_LOAD) && (w_state_nxt == ST_PLAY)) begin
        r_tone <= w_rom_tone;
        r_dur  <= w_rom_dur;
        r_div  <= '0;
        r_tick <= '0;
      end else if (r_state == ST_PLAY) begin
        if (r_div == DIV_LAST) begin
          r_div  <= '0;
          r_tick <= r_tick + 1'b1;
        end else begin
          r_div  <= r_div + 1'b1;
        end
      end

      if (r_state != ST_GAP) r_gap <= '0;
      else                   r_gap <= r_gap + 1'b1;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;
  localparam int TD    = 9;
  localparam int GC    = 3;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  melody_sequencer_if #(.ADDR_W(AW)) ifa ();
  melody_sequencer_if #(.ADDR_W(AW)) ifb ();

  melody_sequencer #(.TICK_DIV(TD), .GAP_CYC(GC), .ADDR_W(AW), .ROM_SEL(1)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .bus(ifa));
  melody_sequencer #(.TICK_DIV(TD), .GAP_CYC(GC), .ADDR_W(AW), .ROM_SEL(2)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .bus(ifb));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Melody of dut_a: {8,1}, {0,0}, {15,0}, {31,x}, rest end markers.
  logic [7:0] rom_a [DEPTH] = '{8'h41, 8'h00, 8'h78, 8'hF8, 8'hF8, 8'hF8, 8'hF8, 8'hF8};

  // Expected outputs, one entry per cycle of the current run; empty = idle.
  logic [10:0] exp_q [$];

  function automatic logic [10:0] pk(input logic en, input logic [4:0] t,
                                     input logic b, input logic dn, input int idx);
    return {en, t, b, dn, 3'(idx)};
  endfunction

  function automatic logic [10:0] sa();
    return {ifa.tone_en, ifa.tone, ifa.busy, ifa.done, ifa.note_idx};
  endfunction

  function automatic logic [10:0] sb();
    return {ifb.tone_en, ifb.tone, ifb.busy, ifb.done, ifb.note_idx};
  endfunction

  function automatic void push_melody();
    logic [4:0] t;
    int         n;
    bit         fin;
    fin = 1'b0;
    for (int i = 0; i < DEPTH && !fin; i++) begin
      t = rom_a[i][7:3];
      n = (int'(rom_a[i][2:0]) + 1) * (TD + 1);
      exp_q.push_back(pk(1'b0, 5'd0, 1'b1, 1'b0, i));
      exp_q.push_back(pk(1'b0, 5'd0, 1'b1, 1'b0, i));
      if (t == 5'd31) begin
        exp_q.push_back(pk(1'b0, 5'd0, 1'b1, 1'b1, i));
        fin = 1'b1;
      end else begin
        for (int c = 0; c < n; c++)
          exp_q.push_back(pk((t >= 5'd1) && (t <= 5'd21), t, 1'b1, 1'b0, i));
        for (int c = 0; c < GC; c++)
          exp_q.push_back(pk(1'b0, 5'd0, 1'b1, 1'b0, i));
      end
    end
    if (!fin) exp_q.push_back(pk(1'b0, 5'd0, 1'b1, 1'b1, DEPTH - 1));
  endfunction

`ifdef MELODY_LOOP_EN
  logic [10:0] last;
`endif

  // Reference model: advances one cycle per clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      if (ifa.stop) begin
        exp_q.delete();
      end else begin
`ifdef MELODY_LOOP_EN
        last = exp_q.pop_front();
        if ((exp_q.size() == 0) && last[3] && (rom_a[0][7:3] != 5'd31)) push_melody();
`else
        void'(exp_q.pop_front());
`endif
      end
    end else if (ifa.play && !ifa.stop) begin
      push_melody();
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [10:0] e;
    logic [10:0] g;
    cyc++;
    if (rst_n) begin
      e = (exp_q.size() != 0) ? exp_q[0] : 11'd0;
      g = sa();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL model cyc=%0d got=%h exp=%h", cyc, g, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic pulse_a(input logic p, input logic s);
    @(negedge clk);
    ifa.play = p;
    ifa.stop = s;
    @(negedge clk);
    ifa.play = 1'b0;
    ifa.stop = 1'b0;
  endtask

  logic [10:0] rec [64];
  int          cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.play = 1'b0; ifa.stop = 1'b0;
    ifb.play = 1'b0; ifb.stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a", 32'(sa()), 32'd0);
    chk("reset_b", 32'(sb()), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed playback; after pulse_a we sit at cycle k=1 (FETCH).
    pulse_a(1'b1, 1'b0);
    for (int k = 1; k < 64; k++) begin
      if (k > 1) @(negedge clk);
      rec[k] = sa();
    end
    chk("fetch_k1", 32'(rec[1]), 32'(pk(0, 0, 1, 0, 0)));
    chk("load_k2",  32'(rec[2]), 32'(pk(0, 0, 1, 0, 0)));
    chk("rise_k3",  32'(rec[3]), 32'(pk(1, 8, 1, 0, 0)));
    chk("last_k22", 32'(rec[22]), 32'(pk(1, 8, 1, 0, 0)));
    chk("gap_k23",  32'(rec[23]), 32'(pk(0, 0, 1, 0, 0)));
    chk("gap_k25",  32'(rec[25]), 32'(pk(0, 0, 1, 0, 0)));
    cnt = 0;
    for (int k = 1; k < 64; k++) if (rec[k][10] && rec[k][2:0] == 3'd0) cnt++;
    chk("note0_len", 32'(cnt), 32'd20);
    chk("rest_k30", 32'(rec[30]), 32'(pk(0, 0, 1, 0, 1)));
    cnt = 0;
    for (int k = 1; k < 64; k++) if (rec[k][10] && rec[k][2:0] == 3'd2) cnt++;
    chk("note2_len", 32'(cnt), 32'd10);
    chk("h1_k45",   32'(rec[45]), 32'(pk(1, 15, 1, 0, 2)));
    chk("end_k58",  32'(rec[58]), 32'(pk(0, 0, 1, 1, 3)));
    cnt = 0;
    for (int k = 1; k < 60; k++) if (rec[k][3]) cnt++;
    chk("done_once", 32'(cnt), 32'd1);
`ifdef MELODY_LOOP_EN
    chk("loop_k59", 32'(rec[59]), 32'(pk(0, 0, 1, 0, 0)));
`else
    chk("idle_k59", 32'(rec[59]), 32'd0);
    chk("idle_k60", 32'(rec[60]), 32'd0);
`endif

    // Stop mid-note at idx 0, then restart from idx 0.
    pulse_a(1'b0, 1'b1);
    pulse_a(1'b1, 1'b0);
    repeat (9) @(negedge clk);
    ifa.stop = 1'b1;
    @(negedge clk);
    ifa.stop = 1'b0;
    chk("stop_out", 32'(sa()), 32'd0);
    pulse_a(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("restart_k3", 32'(sa()), 32'(pk(1, 8, 1, 0, 0)));
    // play while busy must not restart
    pulse_a(1'b1, 1'b0);
    repeat (40) @(negedge clk);
    chk("no_restart", 32'(sa()[2:0]), 32'd2);

    // play and stop together from IDLE
    pulse_a(1'b0, 1'b1);
    pulse_a(1'b1, 1'b1);
    chk("ps_busy", 32'(ifa.busy), 32'd0);
    @(negedge clk);
    chk("ps_busy2", 32'(ifa.busy), 32'd0);

    // Empty melody on dut_b.
    @(negedge clk);
    ifb.play = 1'b1;
    @(negedge clk);
    ifb.play = 1'b0;
    chk("empty_k1", 32'(sb()), 32'(pk(0, 0, 1, 0, 0)));
    repeat (2) @(negedge clk);
    chk("empty_k3", 32'(sb()), 32'(pk(0, 0, 1, 1, 0)));
    @(negedge clk);
    chk("empty_k4", 32'(sb()), 32'd0);

    // Asynchronous reset mid-note.
    pulse_a(1'b1, 1'b0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'(sa()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized play/stop traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      int r;
      @(negedge clk);
      r = int'($urandom_range(0, 199));
      ifa.play = (r < 12);
      ifa.stop = (r >= 198) || (r == 0);
    end
    @(negedge clk);
    ifa.play = 1'b0;
    ifa.stop = 1'b0;
    repeat (100) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
